wallace_tree_reduction: RTL and testbench

- Unsigned 5x5-bit multiplier front end. Generates partial products and reduces them with a Wallace carry-save tree to two 10-bit rows, r1 and r2, where r1 + r2 (mod 2^10) equals a*b.
- Sits ahead of a shared carry-propagate adder in the datapath. The final addition is deliberately left out, except under the optional feature below.
- Output rows are registered: one pipeline stage.

---
 rtl/wallace_pkg.sv | 11 +
 rtl/wallace_csa.sv | 23 ++
 rtl/wallace_tree_reduction.sv | 98 +++++++++
 tb/tb_wallace_tree_reduction.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/wallace_pkg.sv
// Shared widths and types for the 5x5 Wallace-tree multiplier front end.
// Imported by wallace_csa and wallace_tree_reduction.
package wallace_pkg;

    localparam int A_W = 5;
    localparam int P_W = 2 * A_W;

    typedef logic [A_W-1:0] operand_t;
    typedef logic [P_W-1:0] result_t;

endpackage

// File: rtl/wallace_csa.sv
// Bitwise 3:2 compressor on three P_W vectors.
// Ports: x_i, y_i, z_i addends; sum_o bitwise sum; carry_o majority shifted
// left by one and truncated to P_W. Columns with a zero input act as half adders.
module wallace_csa
    import wallace_pkg::*;
(
    input  result_t x_i,
    input  result_t y_i,
    input  result_t z_i,
    output result_t sum_o,
    output result_t carry_o
);

    always_comb begin
        sum_o   = x_i ^ y_i ^ z_i;
        carry_o = '0;
        // The top column's carry would land at weight P_W and is dropped.
        for (int i = 0; i < P_W - 1; i++) begin
            carry_o[i+1] = (x_i[i] & y_i[i]) | (x_i[i] & z_i[i]) | (y_i[i] & z_i[i]);
        end
    end

endmodule

// File: rtl/wallace_tree_reduction.sv
// Unsigned 5x5 multiplier front end: partial products reduced by a 3-stage
// Wallace tree into registered carry-save rows r1 (sum) and r2 (carry).
// Ports: clk, rst_n (async, active low), in_valid/a/b in; out_valid/r1/r2 out.
// Optional macro WALLACE_FINAL_ADD_EN adds a registered ripple-adder product port.
module wallace_tree_reduction
    import wallace_pkg::*;
(
    input  logic     clk,
    input  logic     rst_n,
    input  logic     in_valid,
    input  operand_t a,
    input  operand_t b,
    output logic     out_valid,
    output result_t  r1,
    output result_t  r2
`ifdef WALLACE_FINAL_ADD_EN
    ,
    output result_t  product
`endif
);

    result_t pp [A_W];
    result_t s1, c1, s2, c2;
    result_t r1_d, r2_d;

    // Row i holds a & b[i], shifted to weight i.
    always_comb begin
        for (int i = 0; i < A_W; i++) begin
            pp[i] = result_t'(a & {A_W{b[i]}}) << i;
        end
    end

    // Stage 1: rows 0-2 -> 2 rows; rows 3 and 4 pass through.
    wallace_csa u_stage1 (
        .x_i     (pp[0]),
        .y_i     (pp[1]),
        .z_i     (pp[2]),
        .sum_o   (s1),
        .carry_o (c1)
    );

    // Stage 2: s1, c1, row 3 -> 2 rows; row 4 passes through.
    wallace_csa u_stage2 (
        .x_i     (s1),
        .y_i     (c1),
        .z_i     (pp[3]),
        .sum_o   (s2),
        .carry_o (c2)
    );

    // Stage 3: final pair of rows.
    wallace_csa u_stage3 (
        .x_i     (s2),
        .y_i     (c2),
        .z_i     (pp[4]),
        .sum_o   (r1_d),
        .carry_o (r2_d)
    );

    // Registers only load on in_valid, so X on idle operands never lands.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            r1        <= '0;
            r2        <= '0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                r1 <= r1_d;
                r2 <= r2_d;
            end
        end
    end

`ifdef WALLACE_FINAL_ADD_EN
    result_t prod_d;
    logic    cy;

    // Ripple carry-propagate adder; carry out of bit P_W-1 is discarded.
    always_comb begin
        prod_d = '0;
        cy     = 1'b0;
        for (int i = 0; i < P_W; i++) begin
            prod_d[i] = r1_d[i] ^ r2_d[i] ^ cy;
            cy        = (r1_d[i] & r2_d[i]) | (cy & (r1_d[i] ^ r2_d[i]));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            product <= '0;
        end else if (in_valid) begin
            product <= prod_d;
        end
    end
`endif

endmodule

// File: tb/tb_wallace_tree_reduction.sv
// Directed self-checking bench for wallace_tree_reduction.
// Covers reset, corner products, back-to-back issue and a full operand sweep.
module tb_wallace_tree_reduction;
    import wallace_pkg::*;

    logic     clk = 1'b0;
    logic     rst_n = 1'b0;
    logic     in_valid = 1'b0;
    operand_t a = '0;
    operand_t b = '0;
    logic     out_valid;
    result_t  r1, r2;
`ifdef WALLACE_FINAL_ADD_EN
    result_t  product;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    wallace_tree_reduction dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .r1        (r1),
        .r2        (r2)
`ifdef WALLACE_FINAL_ADD_EN
        ,
        .product   (product)
`endif
    );

    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic int rowsum();
        result_t s;
        s = r1 + r2;
        return int'(s);
    endfunction

    // Present inputs, take one edge, then sample just after it.
    task automatic step(input logic v, input int av, input int bv);
        in_valid = v;
        a = operand_t'(av);
        b = operand_t'(bv);
        @(posedge clk);
        #1;
    endtask

    task automatic check_prod(input string tag, input int exp);
        check({tag, "_vld"}, int'(out_valid), 1);
        check({tag, "_sum"}, rowsum(), exp);
`ifdef WALLACE_FINAL_ADD_EN
        check({tag, "_prod"}, int'(product), exp);
`endif
    endtask

    initial begin
        #2;
        check("rst_vld", int'(out_valid), 0);
        check("rst_r1", int'(r1), 0);
        check("rst_r2", int'(r2), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        step(1'b1, 5, 7);
        check_prod("p5x7", 35);
        step(1'b0, 0, 0);
        check("idle_vld", int'(out_valid), 0);
        check("idle_hold", rowsum(), 35);

        step(1'b1, 15, 0);
        check_prod("p15x0", 0);
        step(1'b1, 0, 31);
        check_prod("p0x31", 0);
        step(1'b1, 31, 31);
        check_prod("p31x31", 961);

        step(1'b1, 10, 21);
        check_prod("b2b0", 210);
        step(1'b1, 1, 1);
        check_prod("b2b1", 1);
        step(1'b1, 31, 1);
        check_prod("b2b2", 31);

        // Mid-stream async reset with in_valid still high.
        in_valid = 1'b1;
        a = 5'd30;
        b = 5'd29;
        #2;
        rst_n = 1'b0;
        #1;
        check("mrst_vld", int'(out_valid), 0);
        check("mrst_r1", int'(r1), 0);
        check("mrst_r2", int'(r2), 0);
        @(posedge clk);
        #1;
        check("mrst_hold_vld", int'(out_valid), 0);
        check("mrst_hold_sum", rowsum(), 0);
        rst_n = 1'b1;
        #2;
        check("rel_vld", int'(out_valid), 0);
        check("rel_r1", int'(r1), 0);
        check("rel_r2", int'(r2), 0);
        step(1'b1, 30, 29);
        check_prod("post_rst", 870);

        // Idle operands carry X; outputs must keep the last result.
        in_valid = 1'b0;
        a = 'x;
        b = 'x;
        @(posedge clk);
        #1;
        check("x_vld", int'(out_valid), 0);
        check("x_hold", rowsum(), 870);

        for (int i = 0; i < 32; i++) begin
            for (int j = 0; j < 32; j++) begin
                step(1'b1, i, j);
                check_prod("sweep", i * j);
            end
        end
        step(1'b0, 0, 0);
        check("end_vld", int'(out_valid), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
